// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered status flags, occupancy count and ack/err handshakes.
// Define SYNC_FIFO_HWM_EN to add the hwm_clr input and the registered high-water-mark output hwm.
module sync_fifo_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AE_TH  = 2,
    parameter int AF_TH  = 14,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  din,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  dout,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
`ifdef SYNC_FIFO_HWM_EN
    input  logic              hwm_clr,
    output logic [ADDR_W:0]   hwm,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] AE_C  = CW'(AE_TH);
    localparam logic [CW-1:0] AF_C  = CW'(AF_TH);

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH=%0d must be a power of two and >= 4", DEPTH);
        end
        if (AE_TH >= AF_TH) begin : g_bad_thresholds
            $error("sync_fifo_param: AE_TH=%0d must be below AF_TH=%0d", AE_TH, AF_TH);
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_param: WIDTH=%0d must be >= 1", WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic [CW-1:0]    wptr_reg, wptr_next;
    logic [CW-1:0]    rptr_reg, rptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             af_reg, af_next;
    logic             ae_reg, ae_next;
    logic             wr_ack_reg, wr_err_reg;
    logic             rd_ack_reg, rd_err_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             wr_ok, rd_ok;

    // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
    always_comb begin
        wr_ok      = wr_en && (!full_reg || rd_en);
        rd_ok      = rd_en && !empty_reg;
        wptr_next  = wr_ok ? wptr_reg + ONE_C : wptr_reg;
        rptr_next  = rd_ok ? rptr_reg + ONE_C : rptr_reg;
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + ONE_C;
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - ONE_C;
        end
        full_next  = (wptr_next[ADDR_W] != rptr_next[ADDR_W]) &&
                     (wptr_next[ADDR_W-1:0] == rptr_next[ADDR_W-1:0]);
        empty_next = (wptr_next == rptr_next);
        af_next    = (count_next >= AF_C);
        ae_next    = (count_next <= AE_C);
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_reg[wptr_reg[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg   <= '0;
            rptr_reg   <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            af_reg     <= 1'b0;
            ae_reg     <= 1'b1;
            wr_ack_reg <= 1'b0;
            wr_err_reg <= 1'b0;
            rd_ack_reg <= 1'b0;
            rd_err_reg <= 1'b0;
            dout_reg   <= '0;
        end else begin
            wptr_reg   <= wptr_next;
            rptr_reg   <= rptr_next;
            count_reg  <= count_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            af_reg     <= af_next;
            ae_reg     <= ae_next;
            wr_ack_reg <= wr_ok;
            wr_err_reg <= wr_en && !wr_ok;
            rd_ack_reg <= rd_ok;
            rd_err_reg <= rd_en && !rd_ok;
            // Read-before-write: a full-FIFO read sees the old entry at the shared slot.
            if (rd_ok) begin
                dout_reg <= mem_reg[rptr_reg[ADDR_W-1:0]];
            end
        end
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [CW-1:0] hwm_reg, hwm_next;

    always_comb begin
        hwm_next = hwm_reg;
        if (hwm_clr) begin
            hwm_next = count_next;
        end else if (count_next > hwm_reg) begin
            hwm_next = count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_reg <= '0;
        end else begin
            hwm_reg <= hwm_next;
        end
    end

    assign hwm = hwm_reg;
`endif

    assign dout         = dout_reg;
    assign full         = full_reg;
    assign almost_full  = af_reg;
    assign empty        = empty_reg;
    assign almost_empty = ae_reg;
    assign wr_ack       = wr_ack_reg;
    assign wr_err       = wr_err_reg;
    assign rd_ack       = rd_ack_reg;
    assign rd_err       = rd_err_reg;
    assign count        = count_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed plus randomized bench for sync_fifo_param, checked against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AE_TH = 2;
    localparam int AF_TH = 14;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [7:0] dout;
    logic       full, almost_full, empty, almost_empty;
    logic       wr_ack, wr_err, rd_ack, rd_err;
    logic [4:0] count;
`ifdef SYNC_FIFO_HWM_EN
    logic       hwm_clr = 1'b0;
    logic [4:0] hwm;
`endif

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AE_TH(AE_TH), .AF_TH(AF_TH)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_ack(rd_ack), .rd_err(rd_err),
`ifdef SYNC_FIFO_HWM_EN
        .hwm_clr(hwm_clr), .hwm(hwm),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_wack = 1'b0, m_werr = 1'b0, m_rack = 1'b0, m_rerr = 1'b0;
    int         m_hwm = 0;
    string      phase = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        count,        n);
        chk("full",         full,         n == DEPTH);
        chk("almost_full",  almost_full,  n >= AF_TH);
        chk("empty",        empty,        n == 0);
        chk("almost_empty", almost_empty, n <= AE_TH);
        chk("wr_ack",       wr_ack,       m_wack);
        chk("wr_err",       wr_err,       m_werr);
        chk("rd_ack",       rd_ack,       m_rack);
        chk("rd_err",       rd_err,       m_rerr);
        chk("dout",         dout,         m_dout);
`ifdef SYNC_FIFO_HWM_EN
        chk("hwm",          hwm,          m_hwm);
`endif
    endtask

    // One clock cycle of requests; model decides outcome from the occupancy before the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        int  n;
        bit  wok, rok;
        wr_en = w;
        din   = d;
        rd_en = r;
        n   = q.size();
        wok = w && (n < DEPTH || r);
        rok = r && (n > 0);
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
        m_wack = wok;
        m_werr = w && !wok;
        m_rack = rok;
        m_rerr = r && !rok;
`ifdef SYNC_FIFO_HWM_EN
        if (hwm_clr) m_hwm = q.size();
        else if (q.size() > m_hwm) m_hwm = q.size();
`endif
        @(posedge clk);
        #1;
        $display("txn %s wr=%0b din=%02h rd=%0b | cnt=%0d dout=%02h wa=%0b we=%0b ra=%0b re=%0b",
                 phase, w, d, r, count, dout, wr_ack, wr_err, rd_ack, rd_err);
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_wack = 1'b0;
        m_werr = 1'b0;
        m_rack = 1'b0;
        m_rerr = 1'b0;
        m_hwm  = 0;
    endtask

    // Reset asserted between edges: outputs must clear before the next clock.
    task automatic async_reset();
        phase = "async_rst";
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        // Power-on reset
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;

        phase = "fill";
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);

        phase = "overflow";
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        phase = "drain";
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_order", dout, 8'(i));
        end

        phase = "underflow";
        step(1'b0, 8'h00, 1'b1);
        chk("uf_rd_err", rd_err, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        phase = "refill";
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        phase = "full_rw";
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h20 + i), 1'b1);
        phase = "drain2";
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

        phase = "empty_rw";
        step(1'b1, 8'h55, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("empty_rw_data", dout, 8'h55);

        phase = "rand_wr";
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        phase = "rand_rd";
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        phase = "rand_mix";
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        phase = "pre_rst";
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h3C, 1'b1);
        async_reset();

`ifdef SYNC_FIFO_HWM_EN
        phase = "hwm";
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
        chk("hwm_10", hwm, 5'd10);
        hwm_clr = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        hwm_clr = 1'b0;
        chk("hwm_clr", hwm, 5'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0);
        chk("hwm_3", hwm, 5'd3);
        async_reset();
`endif

        phase = "post_rst";
        step(1'b1, 8'hC3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_data", dout, 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
